// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, row drive
// patterns and the helpers that turn a sampled column pattern into a hex code.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] ROW_PAT [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Lowest active-low column wins; only meaningful when exactly one bit is low.
  function automatic logic [3:0] code_of(input logic [1:0] row, input logic [3:0] pat);
    logic [1:0] col;
    col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!pat[i]) col = 2'(i);
    end
    return {row, col};
  endfunction

  function automatic logic onehot0_low(input logic [3:0] pat);
    logic [2:0] zeros;
    zeros = 3'd0;
    for (int i = 0; i < 4; i++) begin
      zeros = zeros + {2'b00, ~pat[i]};
    end
    return (zeros == 3'd1);
  endfunction

endpackage

// File: rtl/keypad_debounce_cnt.sv
// Stability counter shared by press and release qualification; done flags
// that the watched pattern has held for DEBOUNCE_CYCLES consecutive cycles.
module keypad_debounce_cnt #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign done = (count_reg == CNT_W'(DEBOUNCE_CYCLES - 1));

endmodule

// File: rtl/keypad_scan32.sv
// 4x4 hex keypad scanner: active-low row strobe, debounced press/release,
// one code per press shifted into a 32-bit entry register.
module keypad_scan32
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_BITS   = 13,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_col,
  input  logic        clr,
  output logic [3:0]  key_row,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_pressed,
  output logic [31:0] key_num
);

  logic [3:0]               col_meta_reg, col_s_reg;
  logic [SCAN_DIV_BITS-1:0] scan_cnt_reg;
  logic [1:0]               row_reg, row_next;
  logic [3:0]               pat_reg, pat_next;
  state_t                   state_reg, state_next;
  logic [3:0]               key_code_reg;
  logic                     key_valid_reg;
  logic [31:0]              key_num_reg;
  logic                     tick, accept, cnt_clear, cnt_enable, cnt_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta_reg <= 4'hF;
      col_s_reg    <= 4'hF;
    end else begin
      col_meta_reg <= key_col;
      col_s_reg    <= col_meta_reg;
    end
  end

  // Free-running divider; the tick only moves the row while scanning.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_reg <= '0;
    end else begin
      scan_cnt_reg <= scan_cnt_reg + 1'b1;
    end
  end

  assign tick = &scan_cnt_reg;

  keypad_debounce_cnt #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .enable(cnt_enable),
    .done  (cnt_done)
  );

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    pat_next   = pat_reg;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      SCAN: begin
        cnt_clear = 1'b1;
        if (tick) begin
          if (col_s_reg != 4'hF) begin
            pat_next   = col_s_reg;
            state_next = DEBOUNCE;
          end else begin
            row_next = row_reg + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (col_s_reg != pat_reg) begin
          state_next = SCAN;
          row_next   = row_reg + 2'd1;
        end else if (cnt_done) begin
          // Multi-key patterns still park in HOLD so they are not re-read.
          accept     = onehot0_low(pat_reg);
          state_next = HOLD;
        end else begin
          cnt_enable = 1'b1;
        end
      end
      HOLD: begin
        cnt_clear = 1'b1;
        if (col_s_reg == 4'hF) state_next = RELEASE;
      end
      RELEASE: begin
        if (col_s_reg != 4'hF) begin
          state_next = HOLD;
        end else if (cnt_done) begin
          state_next = SCAN;
          row_next   = row_reg + 2'd1;
        end else begin
          cnt_enable = 1'b1;
        end
      end
      default: state_next = SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= SCAN;
      row_reg   <= 2'd0;
      pat_reg   <= 4'hF;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      pat_reg   <= pat_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_valid_reg <= 1'b0;
      key_code_reg  <= 4'h0;
      key_num_reg   <= 32'h0;
    end else begin
      key_valid_reg <= accept;
      if (accept) begin
        key_code_reg <= code_of(row_reg, pat_reg);
        key_num_reg  <= clr ? {28'h0, code_of(row_reg, pat_reg)}
                            : {key_num_reg[27:0], code_of(row_reg, pat_reg)};
      end else if (clr) begin
        key_num_reg <= 32'h0;
      end
    end
  end

  assign key_row     = ROW_PAT[row_reg];
  assign key_code    = key_code_reg;
  assign key_valid   = key_valid_reg;
  assign key_pressed = (state_reg == HOLD) || (state_reg == RELEASE);
  assign key_num     = key_num_reg;

endmodule

// File: tb/tb_keypad_scan32.sv
// Bench for keypad_scan32: simulated key matrix, behavioural model, per-cycle
// comparison plus directed literal checks and a randomized press sequence.
module tb_keypad_scan32;

  localparam int SDB = 2;
  localparam int DB  = 8;
  localparam int CW  = 16;

  localparam int P_IDLE = 0;
  localparam int P_QUAL = 1;
  localparam int P_HELD = 2;
  localparam int P_REL  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [3:0]  key_col, key_row, key_code;
  logic        key_valid, key_pressed;
  logic [31:0] key_num;
  logic [15:0] keys = 16'h0;   // bit 4*row+col set while that key is held

  int checks   = 0;
  int failures = 0;
  int vcnt     = 0;

  always #5 clk = ~clk;

  keypad_scan32 #(
    .SCAN_DIV_BITS  (SDB),
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_col    (key_col),
    .clr        (clr),
    .key_row    (key_row),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_pressed(key_pressed),
    .key_num    (key_num)
  );

  // Physical matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    key_col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!key_row[r]) begin
        for (int c = 0; c < 4; c++) begin
          if (keys[4*r+c]) key_col[c] = 1'b0;
        end
      end
    end
  end

  typedef struct packed {
    int          cnt;
    int          row;
    int          phase;
    int          run;
    logic [3:0]  s1;
    logic [3:0]  cs;
    logic [3:0]  pat;
    logic [3:0]  code;
    logic [31:0] num;
    logic        valid;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t m_reset();
    mstate_t s;
    s    = '0;
    s.s1 = 4'hF;
    s.cs = 4'hF;
    return s;
  endfunction

  function automatic int low_col(logic [3:0] p);
    for (int c = 0; c < 4; c++) if (!p[c]) return c;
    return 0;
  endfunction

  function automatic mstate_t m_next(mstate_t s, logic [3:0] col, logic c);
    mstate_t n;
    logic    tk;
    n       = s;
    n.valid = 1'b0;
    tk      = (s.cnt % (1 << SDB)) == ((1 << SDB) - 1);
    n.cnt   = s.cnt + 1;
    case (s.phase)
      P_IDLE: begin
        if (tk) begin
          if (s.cs != 4'hF) begin
            n.pat = s.cs; n.phase = P_QUAL; n.run = 0;
          end else begin
            n.row = (s.row + 1) % 4;
          end
        end
      end
      P_QUAL: begin
        if (s.cs != s.pat) begin
          n.phase = P_IDLE; n.row = (s.row + 1) % 4;
        end else if (s.run == DB - 1) begin
          if ($countones(~s.pat) == 1) begin
            n.valid = 1'b1;
            n.code  = 4'(4 * s.row + low_col(s.pat));
            n.num   = {s.num[27:0], n.code};
          end
          n.phase = P_HELD;
        end else begin
          n.run = s.run + 1;
        end
      end
      P_HELD: begin
        if (s.cs == 4'hF) begin
          n.phase = P_REL; n.run = 0;
        end
      end
      default: begin
        if (s.cs != 4'hF) begin
          n.phase = P_HELD;
        end else if (s.run == DB - 1) begin
          n.phase = P_IDLE; n.row = (s.row + 1) % 4;
        end else begin
          n.run = s.run + 1;
        end
      end
    endcase
    if (c) n.num = n.valid ? {28'h0, n.code} : 32'h0;
    n.cs = s.s1;
    n.s1 = col;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= m_reset();
    else     m <= m_next(m, key_col, clr);
  end

  logic [3:0] e_row;
  logic       e_pressed;
  assign e_row     = ~(4'd1 << m.row[1:0]);
  assign e_pressed = (m.phase == P_HELD) || (m.phase == P_REL);

  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if (key_row !== e_row || key_valid !== m.valid || key_code !== m.code ||
          key_pressed !== e_pressed || key_num !== m.num) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t row=%b/%b valid=%b/%b code=%h/%h pressed=%b/%b num=%h/%h (got/exp)",
                 $time, key_row, e_row, key_valid, m.valid, key_code, m.code,
                 key_pressed, e_pressed, key_num, m.num);
      end
      if (key_valid === 1'b1) vcnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic press(input logic [15:0] mask, input int hold, input int rel);
    keys = mask;
    repeat (hold) @(negedge clk);
    keys = 16'h0;
    repeat (rel) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          v0;
    int          waited;
    logic [3:0]  seen;
    logic [3:0]  codes [0:8];
    logic [15:0] mask;
    int          hold, rel;

    codes = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hF};

    repeat (3) @(negedge clk);
    check("rst_row", 32'(key_row), 32'hE);
    check("rst_valid", 32'(key_valid), 0);
    check("rst_code", 32'(key_code), 0);
    check("rst_pressed", 32'(key_pressed), 0);
    check("rst_num", key_num, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    v0 = vcnt;
    press(16'(1 << 9), 60, 40);
    check("s1_pulses", 32'(vcnt - v0), 1);
    check("s1_code", 32'(key_code), 9);
    check("s1_num", key_num, 32'h9);
    $display("txn press r2c1 num=%h", key_num);

    press(16'(1 << 3), 60, 40);
    check("s2_num", key_num, 32'h93);
    $display("txn press r0c3 num=%h", key_num);

    v0   = vcnt;
    seen = 4'h0;
    for (int i = 0; i < 80; i++) begin
      keys = (i < 50 && ((i / 5) % 2) == 0) ? 16'(1 << 6) : 16'h0;
      @(negedge clk);
      seen = seen | ~key_row;
    end
    check("s3_pulses", 32'(vcnt - v0), 0);
    check("s3_num", key_num, 32'h93);
    check("s3_rows_seen", 32'(seen), 32'hF);
    $display("txn bounce r1c2 num=%h rows_seen=%b", key_num, seen);

    for (int i = 0; i < 9; i++) begin
      press(16'(1 << codes[i]), 40, 30);
      $display("txn press code=%h num=%h", codes[i], key_num);
    end
    check("s4_num", key_num, 32'h2345678F);

    v0   = vcnt;
    keys = 16'(1 << 4) | 16'(1 << 6);
    repeat (40) @(negedge clk);
    check("s5_pressed_held", 32'(key_pressed), 1);
    keys = 16'h0;
    repeat (5) @(negedge clk);
    check("s5_pressed_rel5", 32'(key_pressed), 1);
    repeat (10) @(negedge clk);
    check("s5_pressed_rel15", 32'(key_pressed), 0);
    check("s5_pulses", 32'(vcnt - v0), 0);
    check("s5_num", key_num, 32'h2345678F);
    $display("txn ghost r1 cols0+2 num=%h", key_num);

    pulse_clr();
    check("s6_clr_only", key_num, 0);
    for (int i = 0; i < 8; i++) press(16'(1 << codes[i]), 40, 30);
    check("s6_pre", key_num, 32'h12345678);
    keys   = 16'(1 << 6);
    waited = 0;
    while (!(m.phase == P_QUAL && m.run == DB - 1 && m.cs == m.pat) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("s6_wait_bound", 32'(waited < 100), 1);
    pulse_clr();
    check("s6_valid", 32'(key_valid), 1);
    check("s6_num", key_num, 32'h6);
    keys = 16'h0;
    repeat (30) @(negedge clk);
    $display("txn clr+valid code=6 num=%h", key_num);

    keys   = 16'(1 << 10);
    waited = 0;
    while (m.phase != P_HELD && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("s7_wait_bound", 32'(waited < 100), 1);
    #2 rst = 1'b1;
    #1;
    check("s7_rst_row", 32'(key_row), 32'hE);
    check("s7_rst_pressed", 32'(key_pressed), 0);
    check("s7_rst_num", key_num, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    v0  = vcnt;
    repeat (60) @(negedge clk);
    check("s7_pulses", 32'(vcnt - v0), 1);
    check("s7_code", 32'(key_code), 32'hA);
    check("s7_num", key_num, 32'hA);
    keys = 16'h0;
    repeat (30) @(negedge clk);
    $display("txn reset-in-hold reaccept num=%h", key_num);

    for (int t = 0; t < 30; t++) begin
      mask = 16'(1 << $urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) mask = mask | 16'(1 << $urandom_range(0, 15));
      hold = $urandom_range(3, 50);
      rel  = $urandom_range(3, 40);
      if ($urandom_range(0, 3) == 0) pulse_clr();
      press(mask, hold, rel);
      $display("txn rand keys=%h hold=%0d rel=%0d num=%h", mask, hold, rel, key_num);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
